// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode/funct encodings,
// fetch FSM states and the fetch-buffer entry layout.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_FULL
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_entry_t;

  // Branch target in word units: (pc+4)/4 + sext(imm)
  function automatic logic [29:0] word_target(
    input logic [29:0] pc4_w,
    input logic [15:0] imm
  );
    return pc4_w + {{14{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port plus
// the fetch-to-decode valid/ready handshake.
interface mips_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic [15:0] branch_imm;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output instr_valid, instr, opcode,
    output funct, pc_plus4,
    input  instr_ready, pc_src, branch_imm
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  instr_valid, instr, opcode,
    input  funct, pc_plus4,
    output instr_ready, pc_src, branch_imm
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc+4, instr} entries.
// Flush wins over a same-cycle push.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  data_i,
  output fetch_entry_t  data_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = CW - 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [CW-1:0] wr_q;
  logic [CW-1:0] rd_q;

  assign count_o = wr_q - rd_q;
  assign valid_o = (count_o != '0);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + CW'(1);
      if (pop_i)  rd_q <= rd_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: PC, single-outstanding
// imem reads, fetch buffer and beq redirect.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  mips_fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [29:0]   pc_q, pc_d;
  logic [29:0]   req_pc_q, req_pc_d;
  logic          discard_q, discard_d;
  logic [CW-1:0] count;
  logic          has_room, accept, redirect;
  logic          issue, push, head_valid;
  fetch_entry_t  head, push_entry;

  assign has_room = (count < CW'(FIFO_DEPTH));
  assign accept   = head_valid & bus.instr_ready;
  assign redirect = accept & bus.pc_src;
  assign issue    = (state_q == S_FETCH) & has_room & ~rst;
  assign push     = (state_q == S_WAIT) & bus.imem_rvalid
                  & ~discard_q;

  assign push_entry.pc_plus4 = {req_pc_q + 30'd1, 2'b00};
  assign push_entry.instr    = bus.imem_rdata;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (accept),
    .flush_i (redirect),
    .data_i  (push_entry),
    .data_o  (head),
    .valid_o (head_valid),
    .count_o (count)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    unique case (state_q)
      S_FETCH: begin
        if (issue) begin
          pc_d     = pc_q + 30'd1;
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end else begin
          state_d  = S_FULL;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          discard_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FULL: begin
        if (accept || has_room) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Any read still in flight after a redirect is stale
    if (redirect) begin
      pc_d = word_target(head.pc_plus4[31:2],
                         bus.branch_imm);
      if (state_d == S_WAIT) discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC[31:2];
      req_pc_q  <= RESET_PC[31:2];
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
    end
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = {pc_q, 2'b00};
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? head.instr : '0;
  assign bus.pc_plus4    = head_valid ? head.pc_plus4 : '0;
  assign bus.opcode      = bus.instr[31:26];
  assign bus.funct       = bus.instr[5:0];

endmodule
